ula_sequencer: RTL and testbench

//  Issues commands to the 5x5 int8 matrix ULA. It fetches matrix A and, for binary ops, matrix B byte-wise

---
 rtl/ula_sequencer_pkg.sv | 48 ++++
 rtl/ula_sequencer_matrix_byte_packer.sv | 29 ++
 rtl/ula_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ula_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_sequencer_pkg.sv
// Shared definitions for the ULA command sequencer: opcodes, FSM states, matrix geometry.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ula_sequencer_pkg;

    localparam int N_ELEM = 25;
    localparam int MAT_W  = 8 * N_ELEM;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_SOMA  = 4'b0011;
    localparam logic [3:0] OP_SUBT  = 4'b0100;
    localparam logic [3:0] OP_MULT  = 4'b0101;
    localparam logic [3:0] OP_OPOS  = 4'b0110;
    localparam logic [3:0] OP_TRANS = 4'b0111;
    localparam logic [3:0] OP_ESCL  = 4'b1000;
    localparam logic [3:0] OP_DET2  = 4'b1001;
    localparam logic [3:0] OP_DET3  = 4'b1010;
    localparam logic [3:0] OP_DET4  = 4'b1011;
    localparam logic [3:0] OP_DET5  = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_SOMA) && (op <= OP_DET5);
    endfunction

    // Only element-wise two-operand ops need matrix B fetched.
    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_SOMA) || (op == OP_SUBT) || (op == OP_MULT);
    endfunction

    function automatic logic [7:0] byte_sel(input logic [MAT_W-1:0] bus, input logic [4:0] idx);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (idx == 5'(k)) b = bus[8*k +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/ula_sequencer_matrix_byte_packer.sv
// Assembles a 25-element int8 matrix one byte at a time into a 200-bit register.
// Latency: a byte presented with load=1 is visible on matrix the cycle after.
// Backpressure: none; every load is accepted, clear has priority over load.
module matrix_byte_packer
    import ula_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [4:0]       idx,
    input  logic [7:0]       data,
    output logic [MAT_W-1:0] matrix
);

    // Insert the byte at element idx; clear wipes stale data from a previous command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix <= '0;
        end else if (clear) begin
            matrix <= '0;
        end else if (load) begin
            for (int k = 0; k < N_ELEM; k++) begin
                if (idx == 5'(k)) matrix[8*k +: 8] <= data;
            end
        end
    end

endmodule

// File: rtl/ula_sequencer.sv
// Sequences one ULA command: fetch A (and B), run the ULA, write 25 result bytes back to RAM.
// Latency: done_op 80 cycles after start for binary ops, 54 for unary (1-cycle ULA); error 1 cycle.
// Backpressure: start is ignored while busy; ULA_TIMEOUT_EN bounds the wait on ula_done.
module ula_sequencer
    import ula_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [7:0]        escalar,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic              busy,
    output logic              done_op,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [3:0]        ula_opcode,
    output logic [7:0]        ula_escalar,
    output logic [MAT_W-1:0]  ula_matriz_a,
    output logic [MAT_W-1:0]  ula_matriz_b,
    input  logic [MAT_W-1:0]  ula_result,
    input  logic              ula_done
);

    localparam int         EXEC_W    = $clog2(TIMEOUT + 1);
    localparam logic [4:0] LAST_IDX  = 5'(N_ELEM - 1);
    localparam logic [4:0] LOAD_LAST = 5'(N_ELEM);

    state_t              state;
    logic [4:0]          cnt;
    logic [EXEC_W-1:0]   exec_cnt;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic [ADDR_W-1:0]   addr_c_q;
    logic [MAT_W-1:0]    result_q;

    logic                cap_a;
    logic                cap_b;
    logic                clr_b;
    logic [4:0]          cap_idx;
    logic [ADDR_W-1:0]   rd_base;

    // Read data trails the request by one cycle, so load cycle cnt captures byte cnt-1.
    assign cap_idx = cnt - 5'd1;
    assign cap_a   = (state == ST_LOAD_A) && (cnt != 5'd0);
    assign cap_b   = (state == ST_LOAD_B) && (cnt != 5'd0);
    assign clr_b   = (state == ST_IDLE) && start;
    assign rd_base = (state == ST_LOAD_A) ? addr_a_q : addr_b_q;

    matrix_byte_packer u_pack_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (1'b0),
        .load   (cap_a),
        .idx    (cap_idx),
        .data   (mem_rd_data),
        .matrix (ula_matriz_a)
    );

    matrix_byte_packer u_pack_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clr_b),
        .load   (cap_b),
        .idx    (cap_idx),
        .data   (mem_rd_data),
        .matrix (ula_matriz_b)
    );

    // Command FSM; every output is registered so RAM and ULA see glitch-free controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            exec_cnt    <= '0;
            op_q        <= OP_NOP;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            result_q    <= '0;
            busy        <= 1'b0;
            done_op     <= 1'b0;
            error       <= 1'b0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            ula_opcode  <= OP_NOP;
            ula_escalar <= '0;
        end else begin
            done_op <= 1'b0;
            error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q        <= opcode;
                        ula_escalar <= escalar;
                        addr_a_q    <= addr_a;
                        addr_b_q    <= addr_b;
                        addr_c_q    <= addr_c;
                        if (is_legal(opcode)) begin
                            state     <= ST_LOAD_A;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_a;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                ST_LOAD_A, ST_LOAD_B: begin
                    if (cnt == LOAD_LAST) begin
                        cnt <= '0;
                        if ((state == ST_LOAD_A) && is_binary(op_q)) begin
                            state     <= ST_LOAD_B;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_b_q;
                        end else begin
                            state      <= ST_EXEC;
                            ula_opcode <= op_q;
                            exec_cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt != LAST_IDX) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= rd_base + ADDR_W'(cnt + 5'd1);
                        end else begin
                            mem_rd_en <= 1'b0;
                            mem_addr  <= '0;
                        end
                    end
                end

                ST_EXEC: begin
                    // ula_done is a registered flag; in the first cycle it still reflects the past.
                    if ((exec_cnt != '0) && ula_done) begin
                        result_q    <= ula_result;
                        ula_opcode  <= OP_NOP;
                        state       <= ST_STORE;
                        cnt         <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= addr_c_q;
                        mem_wr_data <= ula_result[7:0];
                    end
`ifdef ULA_TIMEOUT_EN
                    else if (exec_cnt == EXEC_W'(TIMEOUT - 1)) begin
                        ula_opcode <= OP_NOP;
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
`endif
                    else if (exec_cnt != '1) begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end

                ST_STORE: begin
                    if (cnt == LAST_IDX) begin
                        mem_wr_en   <= 1'b0;
                        mem_addr    <= '0;
                        mem_wr_data <= '0;
                        done_op     <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt         <= cnt + 5'd1;
                        mem_addr    <= addr_c_q + ADDR_W'(cnt + 5'd1);
                        mem_wr_data <= byte_sel(result_q, cnt + 5'd1);
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequencer.sv
// Scoreboard bench for ula_sequencer: RAM and ULA models, reference expectations from RAM image.
// Latency: checks done_op at 80/54 cycles after start and error 1 cycle after an illegal start.
// Backpressure: busy-time starts are never issued; timeout behaviour follows ULA_TIMEOUT_EN.
module tb_ula_sequencer;

    localparam int AW = 9;
    localparam int NE = 25;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    opcode;
    logic [7:0]    escalar;
    logic [AW-1:0] addr_a, addr_b, addr_c;
    logic          busy, done_op, error;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [7:0]    mem_rd_data, mem_wr_data;
    logic [3:0]    ula_opcode;
    logic [7:0]    ula_escalar;
    logic [199:0]  ula_matriz_a, ula_matriz_b, ula_result;
    logic          ula_done;

    ula_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .escalar      (escalar),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .addr_c       (addr_c),
        .busy         (busy),
        .done_op      (done_op),
        .error        (error),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .ula_opcode   (ula_opcode),
        .ula_escalar  (ula_escalar),
        .ula_matriz_a (ula_matriz_a),
        .ula_matriz_b (ula_matriz_b),
        .ula_result   (ula_result),
        .ula_done     (ula_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    // Reference ULA arithmetic: plain sum for SOMA, an operand-mixing function otherwise.
    function automatic logic [7:0] ref_byte(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] e, input int k);
        if (op == 4'b0011) return a + b;
        return a + 8'(b * 8'd3) + e + {4'b0000, op} + 8'(k);
    endfunction

    // RAM model: 1-cycle read latency, plus a host port for preloading.
    logic [7:0]    ram [512];
    logic [7:0]    img [512];
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_dat;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        else if (host_we) ram[host_addr] <= host_dat;
    end

    // ULA model: registered done one cycle after a non-NOP opcode, unless muted.
    logic ula_mute;
    always @(posedge clk) begin
        ula_done <= (ula_opcode != 4'd0) && !ula_mute;
        for (int k = 0; k < NE; k++)
            ula_result[8*k +: 8] <= ref_byte(ula_opcode, ula_matriz_a[8*k +: 8],
                                             ula_matriz_b[8*k +: 8], ula_escalar, k);
    end

    // Scoreboard queues and current-command expectations.
    logic [AW-1:0]   exp_rd [$];
    logic [AW+7:0]   exp_wr [$];
    int              exp_done [$];
    int              exp_err [$];
    logic [3:0]      exp_op;
    logic [7:0]      exp_esc;
    logic [199:0]    exp_a, exp_b;

    // Monitor: pops and compares whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en && mem_wr_en) flag("rd_wr_overlap");
            if (done_op && error) flag("done_error_overlap");
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) flag("read_unexpected");
                else chk("read_addr", 256'(mem_addr), 256'(exp_rd.pop_front()));
            end
            if (mem_wr_en) begin
                if (exp_wr.size() == 0) flag("write_unexpected");
                else chk("write_addr_data", 256'({mem_addr, mem_wr_data}), 256'(exp_wr.pop_front()));
            end
            if (done_op) begin
                if (exp_done.size() == 0) flag("done_unexpected");
                else chk("done_cycle", 256'(cyc), 256'(exp_done.pop_front()));
            end
            if (error) begin
                if (exp_err.size() == 0) flag("error_unexpected");
                else chk("error_cycle", 256'(cyc), 256'(exp_err.pop_front()));
            end
            if (ula_opcode != 4'd0) begin
                chk("ula_opcode", 256'(ula_opcode), 256'(exp_op));
                chk("ula_escalar", 256'(ula_escalar), 256'(exp_esc));
                chk("ula_matriz_a", 256'(ula_matriz_a), 256'(exp_a));
                chk("ula_matriz_b", 256'(ula_matriz_b), 256'(exp_b));
            end
        end
    end

    task automatic fill(input logic [AW-1:0] base, input bit rnd, input logic [7:0] val);
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            host_we   = 1'b1;
            host_addr = base + AW'(k);
            host_dat  = rnd ? 8'($urandom) : val;
            img[host_addr] = host_dat;
        end
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        exp_err.delete();
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] e,
                         input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        logic          legal, bin;
        logic [AW-1:0] ad;
        logic [199:0]  ea, eb;
        legal = (op >= 4'b0011) && (op <= 4'b1100);
        bin   = (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0101);
        @(negedge clk);
        if (!legal) begin
            exp_err.push_back(cyc + 1);
        end else begin
            ea = '0;
            eb = '0;
            for (int k = 0; k < NE; k++) begin
                ad = a + AW'(k);
                exp_rd.push_back(ad);
                ea[8*k +: 8] = img[ad];
            end
            if (bin) begin
                for (int k = 0; k < NE; k++) begin
                    ad = b + AW'(k);
                    exp_rd.push_back(ad);
                    eb[8*k +: 8] = img[ad];
                end
            end
            exp_a   = ea;
            exp_b   = eb;
            exp_op  = op;
            exp_esc = e;
            if (!ula_mute) begin
                for (int k = 0; k < NE; k++)
                    exp_wr.push_back({c + AW'(k), ref_byte(op, ea[8*k +: 8], eb[8*k +: 8], e, k)});
                exp_done.push_back(cyc + (bin ? 80 : 54));
            end else begin
`ifdef ULA_TIMEOUT_EN
                exp_err.push_back(cyc + (bin ? 52 : 26) + 17);
`endif
            end
        end
        start   = 1'b1;
        opcode  = op;
        escalar = e;
        addr_a  = a;
        addr_b  = b;
        addr_c  = c;
        @(negedge clk);
        start   = 1'b0;
        opcode  = 4'($urandom);
        escalar = 8'($urandom);
        addr_a  = AW'($urandom);
        addr_b  = AW'($urandom);
        addr_c  = AW'($urandom);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_done.size() != 0 || exp_err.size() != 0) && n < budget);
        if (busy || exp_done.size() != 0 || exp_err.size() != 0) begin
            flag({nm, "_wait_timeout"});
            flush();
        end
        chk({nm, "_reads_left"}, 256'(exp_rd.size()), 256'(0));
        chk({nm, "_writes_left"}, 256'(exp_wr.size()), 256'(0));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 256'(busy), 256'(0));
        chk({nm, "_done_op"}, 256'(done_op), 256'(0));
        chk({nm, "_error"}, 256'(error), 256'(0));
        chk({nm, "_mem_rd_en"}, 256'(mem_rd_en), 256'(0));
        chk({nm, "_mem_wr_en"}, 256'(mem_wr_en), 256'(0));
        chk({nm, "_mem_addr"}, 256'(mem_addr), 256'(0));
        chk({nm, "_mem_wr_data"}, 256'(mem_wr_data), 256'(0));
        chk({nm, "_ula_opcode"}, 256'(ula_opcode), 256'(0));
        chk({nm, "_ula_escalar"}, 256'(ula_escalar), 256'(0));
        chk({nm, "_matriz_a"}, 256'(ula_matriz_a), 256'(0));
        chk({nm, "_matriz_b"}, 256'(ula_matriz_b), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]    op;
        logic [AW-1:0] ra, rb, rc;
        bit            hit;
        rst_n = 1'b0;  start = 1'b0; opcode = '0; escalar = '0;
        addr_a = '0;   addr_b = '0;  addr_c = '0;
        host_we = 1'b0; host_addr = '0; host_dat = '0;
        ula_mute = 1'b0;
        exp_op = '0; exp_esc = '0; exp_a = '0; exp_b = '0;
        for (int i = 0; i < 512; i++) img[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // 1: binary sum, A=0x01, B=0x02, result 0x03 at 0x040..0x058.
        fill(9'h000, 1'b0, 8'h01);
        fill(9'h020, 1'b0, 8'h02);
        issue(4'b0011, 8'h00, 9'h000, 9'h020, 9'h040);
        wait_idle("t1", 200);
        for (int k = 0; k < NE; k++) chk("t1_ram", 256'(ram[9'h040 + AW'(k)]), 256'(8'h03));

        // 2: unary op, no B reads, B bus zero.
        fill(9'h100, 1'b1, 8'h00);
        fill(9'h020, 1'b1, 8'h00);
        issue(4'b0110, 8'h5A, 9'h100, 9'h020, 9'h180);
        wait_idle("t2", 200);

        // 3: illegal opcodes.
        issue(4'b0000, 8'h11, 9'h000, 9'h020, 9'h040);
        chk("t3_busy_0000", 256'(busy), 256'(0));
        wait_idle("t3a", 20);
        issue(4'b1111, 8'h22, 9'h000, 9'h020, 9'h040);
        chk("t3_busy_1111", 256'(busy), 256'(0));
        wait_idle("t3b", 20);

        // 4: address wrap on A.
        fill(9'h1F0, 1'b1, 8'h00);
        issue(4'b0111, 8'h33, 9'h1F0, 9'h000, 9'h0A0);
        wait_idle("t4", 200);

        // 5: reset during STORE element 10.
        fill(9'h050, 1'b1, 8'h00);
        issue(4'b1000, 8'h44, 9'h050, 9'h000, 9'h0C0);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            if (mem_wr_en && mem_addr == 9'h0CA) hit = 1'b1;
        end
        if (!hit) flag("t5_store_k10_not_seen");
        #2 rst_n = 1'b0;
        #1 chk_zero("t5_async");
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_busy_after", 256'(busy), 256'(0));
        fill(9'h060, 1'b1, 8'h00);
        fill(9'h090, 1'b1, 8'h00);
        issue(4'b0100, 8'h55, 9'h060, 9'h090, 9'h0E0);
        wait_idle("t5_next", 200);

        // 6: ULA never answers.
        ula_mute = 1'b1;
        fill(9'h000, 1'b1, 8'h00);
        issue(4'b0110, 8'h66, 9'h000, 9'h000, 9'h100);
`ifdef ULA_TIMEOUT_EN
        wait_idle("t6", 200);
        chk("t6_busy", 256'(busy), 256'(0));
`else
        repeat (150) @(negedge clk);
        #1;
        chk("t6_busy_held", 256'(busy), 256'(1));
        chk("t6_opcode_held", 256'(ula_opcode), 256'(4'b0110));
        chk("t6_reads_left", 256'(exp_rd.size()), 256'(0));
        rst_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        ula_mute = 1'b0;

        // Randomized commands.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
            else op = 4'($urandom_range(3, 12));
            ra = AW'($urandom);
            rb = AW'($urandom);
            rc = AW'($urandom);
            fill(ra, 1'b1, 8'h00);
            fill(rb, 1'b1, 8'h00);
            issue(op, 8'($urandom), ra, rb, rc);
            wait_idle("rand", 200);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
